// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Definitions shared by the memory responder and the CPU side of the bus:
//   mem_state_t      responder mode (image load or normal bus service)
//   rd_sel_t         source selected for the registered bus read data
//   CON_ADDR_DEF     console data register address (write-only)
//   STATUS_ADDR_DEF  console status word address (read-only)
//   OVF_BIT/CNT_LSB  bit layout of the console status word
// -----------------------------------------------------------------------------
package proc_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SEL_ZERO   = 2'd0,
        SEL_RAM    = 2'd1,
        SEL_STATUS = 2'd2
    } rd_sel_t;

    localparam logic [15:0] CON_ADDR_DEF    = 16'hFF00;
    localparam logic [15:0] STATUS_ADDR_DEF = 16'hFF01;

    // Status word: overflow flag in the top bit, byte count in the low byte.
    localparam int OVF_BIT = 15;
    localparam int CNT_LSB = 0;

endpackage

// File: rtl/console_fifo.sv
// -----------------------------------------------------------------------------
// console_fifo
// Byte FIFO buffering console output between the CPU bus and the sink.
//   clk, rst    clock and synchronous active-high reset (empties the FIFO)
//   push        enqueue push_data; taken when not full, or when full and a
//               pop happens in the same cycle
//   push_data   byte to enqueue
//   pop         dequeue the head; ignored while empty
//   head        current head entry (meaningful only when !empty)
//   count       number of stored entries, 0..FIFO_DEPTH
//   full/empty  occupancy flags
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module console_fifo
    import proc_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [7:0]    mem_reg [FIFO_DEPTH];
    logic          do_pop;
    logic          do_push;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(FIFO_DEPTH));
    assign count = count_reg;
    assign head  = mem_reg[rd_ptr_reg];

    // A full FIFO still takes a push when the head leaves in the same cycle:
    // the freed slot is the one the write pointer is about to reuse.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; entries are only observed below the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the processor bus. After reset it accepts a
// program image over a valid/ready load stream while holding the CPU in reset,
// then serves bus reads/writes to a word RAM and a memory-mapped console.
//   clk, rst               clock, synchronous active-high reset
//   addr, we, toMem        bus word address, write strobe, write data
//   fromMem                registered read data (one-cycle latency)
//   cpu_hold               high while loading; drives the CPU reset
//   load_valid/data/last   image stream in; load_ready accepts a word
//   load_err               sticky: image ran past the last RAM word
//   con_valid/data/ready   console byte stream out of the FIFO
// -----------------------------------------------------------------------------
module mem_responder
    import proc_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] CON_ADDR    = CON_ADDR_DEF,
    parameter logic [15:0] STATUS_ADDR = STATUS_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [15:0] toMem,
    output logic [15:0] fromMem,
    output logic        cpu_hold,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_err,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    mem_state_t    state_reg;
    logic [AW-1:0] ptr_reg;
    logic          load_ready_reg;
    logic          load_err_reg;
    logic          cpu_hold_reg;
    logic          ovf_reg;

    logic [15:0]   ram [DEPTH];
    logic [15:0]   ram_rd_reg;
    logic [15:0]   status_rd_reg;
    rd_sel_t       rd_sel_reg;

    logic          addr_in_ram;
    logic          load_beat;
    logic          load_done;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [15:0]   ram_wdata;

    logic          con_push;
    logic          con_pop;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [15:0]   status_word;

    assign addr_in_ram = ({1'b0, addr} < 17'(DEPTH));

    // ---------------------------------------------------------------- load FSM
    assign load_beat = (state_reg == LOAD) & load_valid & load_ready_reg;
    // Reaching the last RAM word ends the image even without load_last.
    assign load_done = load_beat & (load_last | (ptr_reg == AW'(DEPTH - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= LOAD;
            ptr_reg        <= '0;
            load_ready_reg <= 1'b0;
            load_err_reg   <= 1'b0;
            cpu_hold_reg   <= 1'b1;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (load_beat) begin
                        ptr_reg <= ptr_reg + AW'(1);
                    end
                    if (load_done) begin
                        state_reg      <= RUN;
                        load_ready_reg <= 1'b0;
                        cpu_hold_reg   <= 1'b0;
                        load_err_reg   <= ~load_last;
                    end else begin
                        load_ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    load_ready_reg <= 1'b0;
                end
                default: begin
                    state_reg <= LOAD;
                end
            endcase
        end
    end

    assign load_ready = load_ready_reg;
    assign load_err   = load_err_reg;
    assign cpu_hold   = cpu_hold_reg;

    // --------------------------------------------------------------------- RAM
    // Single write port shared by the loader and the bus; the two never
    // compete because bus writes are ignored until the image is in.
    assign ram_we    = load_beat | ((state_reg == RUN) & we & addr_in_ram);
    assign ram_waddr = (state_reg == LOAD) ? ptr_reg : addr[AW-1:0];
    assign ram_wdata = (state_reg == LOAD) ? load_data : toMem;

    // Read and write in the same block give read-before-write on a collision.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
        ram_rd_reg <= ram[addr[AW-1:0]];
    end

    // ---------------------------------------------------------------- read mux
    always_comb begin
        status_word                 = '0;
        status_word[OVF_BIT]        = ovf_reg;
        status_word[CNT_LSB +: 8]   = 8'(fifo_count);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel_reg    <= SEL_ZERO;
            status_rd_reg <= '0;
        end else begin
            status_rd_reg <= status_word;
            if (state_reg != RUN) begin
                rd_sel_reg <= SEL_ZERO;
            end else if (addr_in_ram) begin
                rd_sel_reg <= SEL_RAM;
            end else if (addr == STATUS_ADDR) begin
                rd_sel_reg <= SEL_STATUS;
            end else begin
                rd_sel_reg <= SEL_ZERO;
            end
        end
    end

    always_comb begin
        case (rd_sel_reg)
            SEL_RAM:    fromMem = ram_rd_reg;
            SEL_STATUS: fromMem = status_rd_reg;
            default:    fromMem = 16'h0000;
        endcase
    end

    // ----------------------------------------------------------------- console
    assign con_push = (state_reg == RUN) & we & (addr == CON_ADDR);
    assign con_pop  = con_valid & con_ready;

    console_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (con_push),
        .push_data (toMem[7:0]),
        .pop       (con_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A push into a full FIFO is lost unless the head drains that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (con_push & fifo_full & ~con_pop) begin
            ovf_reg <= 1'b1;
        end
    end

    assign con_valid = ~fifo_empty;
    assign con_data  = fifo_empty ? 8'h00 : fifo_head;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed scenarios with literal expectations, followed by randomized load and
// bus traffic. A queue/array model of the responder is stepped on every rising
// edge and compared against the DUT outputs on every falling edge.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int DEPTH = 8;
    localparam int FD    = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic        we = 1'b0;
    logic [15:0] toMem = '0;
    logic [15:0] fromMem;
    logic        cpu_hold;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        load_err;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .we         (we),
        .toMem      (toMem),
        .fromMem    (fromMem),
        .cpu_hold   (cpu_hold),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_err   (load_err),
        .con_valid  (con_valid),
        .con_data   (con_data),
        .con_ready  (con_ready)
    );

    // ------------------------------------------------------------ model state
    logic [15:0]  m_ram [DEPTH];
    bit           m_known [DEPTH];
    bit           m_ok = 1'b0;
    bit           m_load;
    bit           m_lready;
    bit           m_err;
    bit           m_ovf;
    int           m_ptr;
    logic [15:0]  m_from;
    bit           m_from_known;
    byte unsigned q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [15:0] rd;
        bit          rd_known;
        bit          pop;
        if (rst) begin
            m_ok = 1'b1; m_load = 1'b1; m_ptr = 0; m_lready = 1'b0;
            m_err = 1'b0; m_ovf = 1'b0; q.delete();
            m_from = 16'h0000; m_from_known = 1'b1;
            return;
        end
        if (!m_ok) return;
        if (m_load) begin
            m_from = 16'h0000; m_from_known = 1'b1;
            if (load_valid && m_lready) begin
                m_ram[m_ptr] = load_data;
                m_known[m_ptr] = 1'b1;
                if (load_last || m_ptr == DEPTH - 1) begin
                    m_load = 1'b0;
                    m_err = !load_last;
                end
                m_ptr++;
            end
            m_lready = m_load;
        end else begin
            rd = 16'h0000; rd_known = 1'b1;
            if (addr < DEPTH) begin
                rd = m_ram[addr]; rd_known = m_known[addr];
            end else if (addr == 16'hFF01) begin
                rd = {m_ovf, 7'b0, 8'(q.size())};
            end
            pop = (q.size() > 0) && con_ready;
            if (we && addr < DEPTH) begin
                m_ram[addr] = toMem; m_known[addr] = 1'b1;
            end
            if (pop) void'(q.pop_front());
            if (we && addr == 16'hFF00) begin
                if (q.size() < FD) q.push_back(toMem[7:0]);
                else m_ovf = 1'b1;
            end
            m_from = rd; m_from_known = rd_known;
        end
    endtask

    task automatic compare_step();
        if (!m_ok) return;
        check("cpu_hold", 16'(cpu_hold), 16'(m_load));
        check("load_ready", 16'(load_ready), 16'(m_lready));
        check("load_err", 16'(load_err), 16'(m_err));
        check("con_valid", 16'(con_valid), 16'(q.size() > 0));
        check("con_data", 16'(con_data), (q.size() > 0) ? 16'(q[0]) : 16'h0000);
        if (m_from_known) check("fromMem", fromMem, m_from);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        fork
            forever begin @(posedge clk); model_step(); end
            forever begin @(negedge clk); compare_step(); end
        join_none

        // ---------------------------------------------------- load then run
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_cpu_hold", 16'(cpu_hold), 16'h1);
        check("rst_load_ready", 16'(load_ready), 16'h0);
        check("rst_fromMem", fromMem, 16'h0000);
        check("rst_con_valid", 16'(con_valid), 16'h0);
        check("rst_load_err", 16'(load_err), 16'h0);
        tick();
        check("load_ready_up", 16'(load_ready), 16'h1);
        load_valid = 1'b1; load_data = 16'hC105; tick();
        load_data = 16'h1001; tick();
        check("hold_mid_load", 16'(cpu_hold), 16'h1);
        load_data = 16'h7777; load_last = 1'b1; tick();
        load_valid = 1'b0; load_last = 1'b0;
        check("run_cpu_hold", 16'(cpu_hold), 16'h0);
        check("run_load_ready", 16'(load_ready), 16'h0);
        check("run_load_err", 16'(load_err), 16'h0);
        addr = 16'd0; tick(); check("rd0", fromMem, 16'hC105);
        addr = 16'd1; tick(); check("rd1", fromMem, 16'h1001);
        addr = 16'd2; tick(); check("rd2", fromMem, 16'h7777);

        // ------------------------------------------------ read-before-write
        addr = 16'd3; we = 1'b1; toMem = 16'h00AA; tick();
        toMem = 16'h0055; tick();
        check("rbw_old", fromMem, 16'h00AA);
        we = 1'b0; tick();
        check("rbw_new", fromMem, 16'h0055);

        // ------------------------------------------- console order/backpressure
        con_ready = 1'b0; we = 1'b1; addr = 16'hFF00; toMem = 16'h1241; tick();
        check("push_visible", 16'(con_valid), 16'h1);
        toMem = 16'h3442; tick();
        we = 1'b0; addr = 16'hFF01; tick();
        check("status_2", fromMem, 16'h0002);
        check("head_41", 16'(con_data), 16'h0041);
        con_ready = 1'b1; tick();
        check("head_42", 16'(con_data), 16'h0042);
        tick();
        check("drained", 16'(con_valid), 16'h0);
        con_ready = 1'b0;

        // --------------------------------------------------- unmapped access
        we = 1'b1; addr = 16'h8000; toMem = 16'hFFFF; tick();
        we = 1'b0; tick(); check("unmapped_rd", fromMem, 16'h0000);
        addr = 16'hFF01; tick(); check("unmapped_status", fromMem, 16'h0000);
        addr = 16'd0; tick(); check("unmapped_ram0", fromMem, 16'hC105);
        addr = 16'd3; tick(); check("unmapped_ram3", fromMem, 16'h0055);

        // ------------------------------------------------------- overflow
        we = 1'b1; addr = 16'hFF00;
        for (int i = 0; i < 9; i++) begin
            toMem = 16'h0010 + 16'(i); tick();
        end
        we = 1'b0; addr = 16'hFF01; tick();
        check("status_ovf", fromMem, 16'h8008);
        we = 1'b1; addr = 16'hFF00; toMem = 16'h0099; con_ready = 1'b1; tick();
        we = 1'b0; con_ready = 1'b0; addr = 16'hFF01; tick();
        check("status_full_pp", fromMem, 16'h8008);
        check("head_after_pp", 16'(con_data), 16'h0011);
        con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_order", 16'(con_data), (i < 7) ? 16'h0011 + 16'(i) : 16'h0099);
            tick();
        end
        check("drain_empty", 16'(con_valid), 16'h0);
        con_ready = 1'b0;

        // ---------------------------------------------------- mid-run reset
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_hold", 16'(cpu_hold), 16'h1);
        check("mid_rst_lready", 16'(load_ready), 16'h0);
        check("mid_rst_from", fromMem, 16'h0000);
        tick();
        load_valid = 1'b1; load_data = 16'h1111; load_last = 1'b1; tick();
        load_valid = 1'b0; load_last = 1'b0;
        addr = 16'hFF01; tick(); check("mid_rst_status", fromMem, 16'h0000);
        addr = 16'd0; tick(); check("reload_rd0", fromMem, 16'h1111);

        // ---------------------------------------------------- oversize image
        rst = 1'b1; tick(); rst = 1'b0; tick();
        load_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            load_data = 16'hA000 + 16'(i); tick();
        end
        check("ovs_err", 16'(load_err), 16'h1);
        check("ovs_lready", 16'(load_ready), 16'h0);
        check("ovs_hold", 16'(cpu_hold), 16'h0);
        load_data = 16'hBEEF; tick();
        load_valid = 1'b0;
        addr = 16'd0; tick(); check("ovs_rd0", fromMem, 16'hA000);
        addr = 16'(DEPTH - 1); tick(); check("ovs_rd_last", fromMem, 16'hA000 + 16'(DEPTH - 1));

        // ------------------------------------------------- randomized traffic
        for (int it = 0; it < 5; it++) begin
            rst = 1'b1; we = 1'b0; tick(); rst = 1'b0;
            for (int c = 0; c < 100 && cpu_hold; c++) begin
                load_valid = 1'($urandom_range(0, 1));
                load_data  = 16'($urandom);
                load_last  = ($urandom_range(0, 5) == 0);
                addr       = 16'($urandom);
                we         = 1'($urandom_range(0, 1));
                tick();
            end
            check("load_bound", 16'(cpu_hold), 16'h0);
            load_last = 1'b0;
            for (int c = 0; c < 400; c++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 5)       addr = 16'($urandom_range(0, DEPTH - 1));
                else if (r < 7)  addr = 16'hFF00;
                else if (r == 7) addr = 16'hFF01;
                else if (r == 8) addr = 16'($urandom);
                else             addr = 16'(DEPTH + $urandom_range(0, 3));
                we         = 1'($urandom_range(0, 1));
                toMem      = 16'($urandom);
                con_ready  = ($urandom_range(0, 2) == 0);
                load_valid = 1'($urandom_range(0, 1));
                load_data  = 16'($urandom);
                tick();
            end
            we = 1'b0; load_valid = 1'b0; con_ready = 1'b0;
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's bus: serves instruction/data reads on fromMem, accepts writes when we is high, and owns a small memory-mapped console.
- After reset it first accepts a program image over a streaming load port while holding the CPU in reset (cpu_hold).
- It then enters RUN and services the bus.
- Console bytes the CPU writes are buffered in a FIFO and drained by a valid/ready sink.

Parameters:
- DEPTH, 256: number of 16-bit RAM words, word-addressed from 0.
- FIFO_DEPTH, 8: console FIFO entries; power of two, at least 2.
- CON_ADDR, 16'hFF00: write-only console data register; toMem[7:0] is pushed.
- STATUS_ADDR, 16'hFF01: read-only console status word.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- addr  in  16  bus word address from CPU.
- we  in  1  bus write strobe from CPU.
- toMem  in  16  bus write data from CPU.
- fromMem  out  16  registered bus read data.
- cpu_hold  out  1  high holds the CPU in reset; driven onto the CPU's rst.
- load_valid  in  1  load word valid.
- load_data  in  16  load word.
- load_last  in  1  marks final load word; qualified by load_valid.
- load_ready  out  1  responder can accept a load word.
- load_err  out  1  sticky: image exceeded DEPTH.
- con_valid  out  1  console byte available.
- con_data  out  8  console byte (FIFO head).
- con_ready  in  1  sink accepts byte.

Behaviour:
- Reset (rst=1 at a clock edge) applies regardless of state or mid-transfer:
  - state=LOAD, load pointer=0.
  - cpu_hold=1, load_ready=0 for the first cycle after reset, then 1 in LOAD.
  - fromMem=0, load_err=0, FIFO empty (con_valid=0, con_data=0), overflow flag=0.
  - RAM contents are not cleared.
- States are LOAD and RUN; no other transitions.
- LOAD:
  - A beat is load_valid & load_ready. It writes RAM[ptr]=load_data and increments ptr.
  - A beat with load_last=1 goes to RUN the next cycle.
  - A beat that writes word DEPTH-1 without load_last also goes to RUN and sets load_err.
  - Leaving LOAD: cpu_hold=0 and load_ready=0 from the first RUN cycle.
  - Bus inputs are ignored; fromMem is held at 0.
- RUN:
  - Stays in RUN until rst. load_valid is ignored and load_ready stays 0.
- Read (RUN), one-cycle latency: fromMem at edge N+1 reflects addr sampled at edge N:
  - addr<DEPTH: RAM[addr].
  - addr==STATUS_ADDR: {overflow, 7'b0, count zero-extended to 8 bits}; count is 0..FIFO_DEPTH.
  - Any other address: 16'h0000.
- Reads ignore we. Same-address read and write in one cycle returns the old RAM data (read-before-write).
- Write (RUN, we=1):
  - addr<DEPTH: RAM[addr]=toMem.
  - addr==CON_ADDR: push toMem[7:0].
  - Other addresses, including STATUS_ADDR: no effect.
- FIFO:
  - Pop occurs when con_valid & con_ready.
  - Push while full is accepted only if a pop occurs in the same cycle; otherwise the byte is dropped and overflow is set (sticky until rst).
  - Push and pop together leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - con_data is the head entry, valid whenever count>0.
  - A pushed byte is visible on con_valid the cycle after the push.
- The CPU's program counter starts at address 0 when cpu_hold falls, so image word 0 is the first fetch.

Decomposition:
- Shared package proc_pkg holds:
  - typedef enum mem_state_t {LOAD, RUN}.
  - localparams CON_ADDR_DEF=16'hFF00 and STATUS_ADDR_DEF=16'hFF01, which also feed the CPU side.
  - Status bit positions: OVF_BIT=15, CNT_LSB=0.
- One sub-module: console_fifo (parameter FIFO_DEPTH, width 8, synchronous reset).
  - Ports: push, push_data, pop, head, count, full, empty.
  - Overflow detection stays in mem_responder.

Test Plan:
- Load then run: rst 1 cycle; stream 16'hC105, 16'h1001, 16'h7777 with load_last on the third -> RAM[0..2] hold those values; cpu_hold falls the cycle after the last beat; load_err=0; addr=0 returns 16'hC105 one cycle later.
- Oversize image: DEPTH=4, stream 4 words without load_last -> RUN after the 4th beat; load_err=1; load_ready=0; the 5th presented word is not written.
- Read-before-write: RUN with RAM[3]=16'h00AA; same cycle we=1, addr=3, toMem=16'h0055 -> next-cycle fromMem=16'h00AA; a following read of 3 gives 16'h0055.
- Console order/backpressure: con_ready=0; write 16'h1241 then 16'h3442 to CON_ADDR -> read STATUS_ADDR gives 16'h0002; raise con_ready -> con_data 8'h41 then 8'h42; then con_valid=0.
- Overflow and simultaneous ops: FIFO_DEPTH=8, con_ready=0; 9 pushes -> status 16'h8008. Then push with con_ready=1 -> count stays 8 and the new byte is at the tail. A mid-run rst -> status 16'h0000, cpu_hold=1, state LOAD.
- Unmapped access: write 16'hFFFF to addr 16'h8000 -> no RAM or FIFO change; a read of 16'h8000 returns 16'h0000.
